// File: rtl/axi_mem_slave_pkg.sv
// Shared constants and FSM state types for the AXI memory slave.
// Optional byte-strobe writes are selected by AXI_MEM_WSTRB_EN (see axi_mem_slave.sv).
package axi_pkg;

   localparam int LEN_WIDTH  = 8;
   localparam int RESP_WIDTH = 2;

   localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wstate_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rstate_e;

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI-style burst bus between a master and the memory slave (AW/W/B/AR/R channels).
interface axi_mem_slave_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1
) ();
   import axi_pkg::*;

   localparam int STROBE_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [LEN_WIDTH-1:0]    awlen;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [STROBE_WIDTH-1:0] wstrb;
   logic                    wlast;
   logic [USER_WIDTH-1:0]   wuser;
   logic                    wvalid;
   logic                    wready;

   logic [RESP_WIDTH-1:0]   bresp;
   logic [USER_WIDTH-1:0]   buser;
   logic                    bvalid;
   logic                    bready;

   logic [ADDR_WIDTH-1:0]   araddr;
   logic [LEN_WIDTH-1:0]    arlen;
   logic                    arvalid;
   logic                    arready;

   logic [DATA_WIDTH-1:0]   rdata;
   logic [RESP_WIDTH-1:0]   rresp;
   logic                    rlast;
   logic [USER_WIDTH-1:0]   ruser;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awlen, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wuser, wvalid,
      output wready,
      output bresp, buser, bvalid,
      input  bready,
      input  araddr, arlen, arvalid,
      output arready,
      output rdata, rresp, rlast, ruser, rvalid,
      input  rready
   );

   modport master (
      output awaddr, awlen, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wuser, wvalid,
      input  wready,
      input  bresp, buser, bvalid,
      output bready,
      output araddr, arlen, arvalid,
      input  arready,
      input  rdata, rresp, rlast, ruser, rvalid,
      output rready
   );

endinterface

// File: rtl/axi_mem_ram.sv
// Word-organised storage: byte-enable write port and registered read port.
// A read and write to the same word in one cycle return the old contents.
module axi_mem_ram #(
   parameter int IDX_W      = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [IDX_W-1:0]        widx,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic                    re,
   input  logic [IDX_W-1:0]        ridx,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [2**IDX_W];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (wbe[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[ridx];
   end

endmodule

// File: rtl/axi_mem_slave.sv
// Burst memory slave with independent write (AW/W/B) and read (AR/R) FSMs.
// Define AXI_MEM_WSTRB_EN to honour wstrb; otherwise every beat writes the full word.
module axi_mem_slave
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1
) (
   input  logic            aclk,
   input  logic            aresetn,
   axi_mem_slave_if.slave  s
);

   localparam int STROBE_WIDTH = DATA_WIDTH / 8;
   localparam int OFF          = $clog2(STROBE_WIDTH);
   localparam int IDX_W        = ADDR_WIDTH - OFF;

   // Held low through reset so the address channels stay quiet until the first edge after release.
   logic rdy;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rdy <= 1'b0;
      else          rdy <= 1'b1;
   end

   // ---------------- write path ----------------
   wstate_e              w_state, w_state_nx;
   logic [IDX_W-1:0]     w_idx;
   logic [LEN_WIDTH-1:0] w_len, w_cnt;
   logic                 w_err;
   logic                 aw_hs, w_hs, b_hs, w_final;

   assign aw_hs   = s.awvalid & s.awready;
   assign w_hs    = s.wvalid & s.wready;
   assign b_hs    = s.bvalid & s.bready;
   assign w_final = (w_cnt == w_len);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) w_state <= W_IDLE;
      else          w_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = w_state;
      s.awready  = 1'b0;
      s.wready   = 1'b0;
      s.bvalid   = 1'b0;
      case (w_state)
         W_IDLE: begin
            s.awready = rdy;
            if (aw_hs) w_state_nx = W_DATA;
         end
         W_DATA: begin
            s.wready = 1'b1;
            if (w_hs && w_final) w_state_nx = W_RESP;
         end
         W_RESP: begin
            s.bvalid = 1'b1;
            if (b_hs) w_state_nx = W_IDLE;
         end
         default: w_state_nx = W_IDLE;
      endcase
   end

   // wlast must appear exactly on the awlen-th beat; any other placement flags the burst.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_idx <= '0;
         w_len <= '0;
         w_cnt <= '0;
         w_err <= 1'b0;
      end else if (aw_hs) begin
         w_idx <= s.awaddr[ADDR_WIDTH-1:OFF];
         w_len <= s.awlen;
         w_cnt <= '0;
         w_err <= 1'b0;
      end else if (w_hs) begin
         w_idx <= w_idx + IDX_W'(1);
         w_cnt <= w_cnt + LEN_WIDTH'(1);
         w_err <= w_err | (w_final ? ~s.wlast : s.wlast);
      end
   end

   assign s.bresp = (s.bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
   assign s.buser = {USER_WIDTH{1'b0}};

   logic [STROBE_WIDTH-1:0] wbe;
`ifdef AXI_MEM_WSTRB_EN
   assign wbe = s.wstrb;
`else
   assign wbe = '1;
`endif

   // ---------------- read path ----------------
   rstate_e              r_state, r_state_nx;
   logic [IDX_W-1:0]     r_idx;
   logic [LEN_WIDTH-1:0] r_len, r_cnt;
   logic                 ar_hs, r_hs, r_final, re;
   logic [IDX_W-1:0]     ridx;
   logic [DATA_WIDTH-1:0] ram_q;

   assign ar_hs   = s.arvalid & s.arready;
   assign r_hs    = s.rvalid & s.rready;
   assign r_final = (r_cnt == r_len);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= R_IDLE;
      else          r_state <= r_state_nx;
   end

   always_comb begin
      r_state_nx = r_state;
      s.arready  = 1'b0;
      s.rvalid   = 1'b0;
      case (r_state)
         R_IDLE: begin
            s.arready = rdy;
            if (ar_hs) r_state_nx = R_DATA;
         end
         R_DATA: begin
            s.rvalid = 1'b1;
            if (r_hs && r_final) r_state_nx = R_IDLE;
         end
         default: r_state_nx = R_IDLE;
      endcase
   end

   // r_idx always points at the word to fetch for the next beat, so an accepted beat
   // immediately launches the following read and the stream has no bubble.
   assign re   = ar_hs | (r_hs & ~r_final);
   assign ridx = ar_hs ? s.araddr[ADDR_WIDTH-1:OFF] : r_idx;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_idx <= '0;
         r_len <= '0;
         r_cnt <= '0;
      end else if (ar_hs) begin
         r_idx <= s.araddr[ADDR_WIDTH-1:OFF] + IDX_W'(1);
         r_len <= s.arlen;
         r_cnt <= '0;
      end else if (r_hs && !r_final) begin
         r_idx <= r_idx + IDX_W'(1);
         r_cnt <= r_cnt + LEN_WIDTH'(1);
      end
   end

   assign s.rdata = s.rvalid ? ram_q : '0;
   assign s.rlast = s.rvalid & r_final;
   assign s.rresp = RESP_OKAY;
   assign s.ruser = {USER_WIDTH{1'b0}};

   axi_mem_ram #(
      .IDX_W      (IDX_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (aclk),
      .we    (w_hs),
      .widx  (w_idx),
      .wdata (s.wdata),
      .wbe   (wbe),
      .re    (re),
      .ridx  (ridx),
      .rdata (ram_q)
   );

   logic unused_ok;
`ifdef AXI_MEM_WSTRB_EN
   assign unused_ok = ^{s.wuser, s.awaddr[OFF-1:0], s.araddr[OFF-1:0]};
`else
   assign unused_ok = ^{s.wuser, s.wstrb, s.awaddr[OFF-1:0], s.araddr[OFF-1:0]};
`endif

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: a byte-level memory model produces expected
// bresp/rdata, queued when bursts are driven and popped as the DUT responds.
module tb_axi_mem_slave;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int UW = 1;

   logic aclk    = 1'b0;
   logic aresetn = 1'b1;

   always #5 aclk = ~aclk;

   axi_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

   axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s       (bus)
   );

   int checks = 0;
   int errs   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   logic [31:0] mdl  [64];
   logic [31:0] wbuf [16];
   logic [31:0] exp_rd [$];
   logic        exp_rl [$];
   logic [1:0]  exp_b  [$];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
`ifdef AXI_MEM_WSTRB_EN
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
`else
      r = nw;
      if (strb == 4'hx) r = old;
`endif
      return r;
   endfunction

   task automatic axi_write(input logic [7:0] addr, input int len, input logic [3:0] strb,
                            input int last_at, output int nbeats);
      int t;
      int idx;
      logic err;
      idx = int'(addr) >> 2;
      err = 1'b0;
      nbeats = 0;
      @(negedge aclk);
      bus.awaddr  = addr;
      bus.awlen   = 8'(len);
      bus.awvalid = 1'b1;
      t = 0;
      while (!bus.awready && t < 50) begin @(negedge aclk); t++; end
      @(negedge aclk);
      bus.awvalid = 1'b0;
      if (t >= 50) begin chk("aw_timeout", 32'd0, 32'd1); return; end
      for (int b = 0; b <= len; b++) begin
         bus.wdata  = wbuf[b];
         bus.wstrb  = strb;
         bus.wlast  = (b == last_at);
         bus.wvalid = 1'b1;
         t = 0;
         while (!bus.wready && t < 50) begin @(negedge aclk); t++; end
         if (t >= 50) begin chk("w_timeout", 32'd0, 32'd1); break; end
         mdl[idx] = merge(mdl[idx], wbuf[b], strb);
         idx = (idx + 1) % 64;
         nbeats++;
         if ((b == len) != (b == last_at)) err = 1'b1;
         @(negedge aclk);
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      exp_b.push_back(err ? 2'b10 : 2'b00);
      chk("wready_after_last", 32'(bus.wready), 32'd0);
      bus.bready = 1'b1;
      t = 0;
      while (!bus.bvalid && t < 50) begin @(negedge aclk); t++; end
      if (t >= 50) begin
         chk("b_timeout", 32'd0, 32'd1);
         void'(exp_b.pop_front());
      end else begin
         chk("bresp", 32'(bus.bresp), 32'(exp_b.pop_front()));
         chk("buser", 32'(bus.buser), 32'd0);
      end
      @(negedge aclk);
      bus.bready = 1'b0;
      chk("bvalid_clear", 32'(bus.bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int len, input bit toggle);
      int t;
      int idx;
      int cyc;
      bit stalled;
      logic [31:0] pd;
      logic pl;
      idx = int'(addr) >> 2;
      for (int b = 0; b <= len; b++) begin
         exp_rd.push_back(mdl[idx]);
         exp_rl.push_back(b == len);
         idx = (idx + 1) % 64;
      end
      @(negedge aclk);
      bus.araddr  = addr;
      bus.arlen   = 8'(len);
      bus.arvalid = 1'b1;
      t = 0;
      while (!bus.arready && t < 50) begin @(negedge aclk); t++; end
      @(negedge aclk);
      bus.arvalid = 1'b0;
      if (t >= 50) begin
         chk("ar_timeout", 32'd0, 32'd1);
         exp_rd.delete();
         exp_rl.delete();
         return;
      end
      chk("r_latency", 32'(bus.rvalid), 32'd1);
      cyc = 0;
      stalled = 1'b0;
      pd = '0;
      pl = 1'b0;
      while (exp_rd.size() > 0 && cyc < 200) begin
         chk("rvalid_in_burst", 32'(bus.rvalid), 32'd1);
         if (stalled) begin
            chk("rdata_hold", bus.rdata, pd);
            chk("rlast_hold", 32'(bus.rlast), 32'(pl));
         end
         bus.rready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (bus.rvalid && bus.rready) begin
            chk("rdata", bus.rdata, exp_rd.pop_front());
            chk("rlast", 32'(bus.rlast), 32'(exp_rl.pop_front()));
            chk("rresp", 32'(bus.rresp), 32'd0);
            stalled = 1'b0;
         end else begin
            stalled = bus.rvalid;
            pd = bus.rdata;
            pl = bus.rlast;
         end
         @(negedge aclk);
         cyc++;
      end
      bus.rready = 1'b0;
      if (exp_rd.size() != 0) begin
         chk("r_timeout", 32'(exp_rd.size()), 32'd0);
         exp_rd.delete();
         exp_rl.delete();
      end
      chk("r_idle_after_last", 32'(bus.rvalid), 32'd0);
   endtask

   int nb;

   initial begin
      bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wuser = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;

      // reset behaviour
      #2 aresetn = 1'b0;
      #1;
      chk("rst_awready", 32'(bus.awready), 32'd0);
      chk("rst_arready", 32'(bus.arready), 32'd0);
      chk("rst_wready",  32'(bus.wready),  32'd0);
      chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
      chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
      chk("rst_rdata",   bus.rdata,        32'd0);
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      #1 chk("rel_awready_pre", 32'(bus.awready), 32'd0);
      @(posedge aclk);
      #1;
      chk("rel_awready", 32'(bus.awready), 32'd1);
      chk("rel_arready", 32'(bus.arready), 32'd1);

      // basic 4-beat burst, then read back
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
      axi_write(8'h10, 3, 4'hF, 3, nb);
      chk("basic_beats", 32'(nb), 32'd4);
      axi_read(8'h10, 3, 1'b0);

      // wrap from the top word to word 0
      wbuf[0] = 32'h11; wbuf[1] = 32'h22;
      axi_write(8'hFC, 1, 4'hF, 1, nb);
      axi_read(8'hFC, 1, 1'b0);
      chk("wrap_word63", mdl[63], 32'h11);
      chk("wrap_word0",  mdl[0],  32'h22);

      // early wlast: all beats still accepted, SLVERR reported
      for (int i = 0; i < 3; i++) wbuf[i] = 32'hC0 + 32'(i);
      axi_write(8'h40, 2, 4'hF, 1, nb);
      chk("early_wlast_beats", 32'(nb), 32'd3);
      // missing wlast also errors
      axi_write(8'h50, 1, 4'hF, 99, nb);
      axi_read(8'h40, 2, 1'b0);

      // byte strobes
      wbuf[0] = 32'h12345678;
      axi_write(8'h80, 0, 4'hF, 0, nb);
      wbuf[0] = 32'hFFFFFFFF;
      axi_write(8'h80, 0, 4'b0101, 0, nb);
`ifdef AXI_MEM_WSTRB_EN
      exp_rd.push_back(32'h12FF56FF);
`else
      exp_rd.push_back(32'hFFFFFFFF);
`endif
      chk("strobe_model", mdl[32], exp_rd.pop_front());
      axi_read(8'h80, 0, 1'b0);

      // backpressure on R
      axi_read(8'h10, 3, 1'b1);

      // random bursts
      for (int k = 0; k < 4; k++) begin
         logic [7:0] a;
         int l;
         a = 8'($urandom_range(0, 255)) & 8'hFC;
         l = $urandom_range(0, 7);
         for (int i = 0; i <= l; i++) wbuf[i] = $urandom;
         axi_write(a, l, 4'hF, l, nb);
         axi_read(a, l, k[0]);
      end

      // rewrite a known region, then reset during beat 2 of a 4-beat read
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
      axi_write(8'h10, 3, 4'hF, 3, nb);
      @(negedge aclk);
      bus.araddr = 8'h10; bus.arlen = 8'd3; bus.arvalid = 1'b1;
      begin
         int t;
         t = 0;
         while (!bus.arready && t < 50) begin @(negedge aclk); t++; end
         if (t >= 50) chk("mr_ar_timeout", 32'd0, 32'd1);
      end
      @(negedge aclk);
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      chk("mr_beat1", bus.rdata, 32'hA0);
      @(negedge aclk);
      chk("mr_beat2_valid", 32'(bus.rvalid), 32'd1);
      aresetn = 1'b0;
      bus.rready = 1'b0;
      #1;
      chk("mr_rvalid", 32'(bus.rvalid), 32'd0);
      chk("mr_rdata",  bus.rdata,        32'd0);
      chk("mr_arready", 32'(bus.arready), 32'd0);
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("mr_arready_rel", 32'(bus.arready), 32'd1);
      chk("mr_rvalid_rel",  32'(bus.rvalid),  32'd0);
      axi_read(8'h10, 3, 1'b0);
      axi_read(8'h80, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0d exp=0", 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: byte-address width; memory depth is 2**ADDR_WIDTH bytes.
REQ-002 Parameter DATA_WIDTH, default 32: data width; STROBE_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter USER_WIDTH, default 1: user-signal width.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low; ports aclk (in, 1, clock) and aresetn (in, 1, async active-low reset).
REQ-005 Write-address ports SHALL be: awaddr in ADDR_WIDTH; awlen in 8 (beats-1); awvalid in 1; awready out 1.
REQ-006 Write-data ports SHALL be: wdata in DATA_WIDTH; wstrb in STROBE_WIDTH; wlast in 1; wuser in USER_WIDTH (ignored); wvalid in 1; wready out 1.
REQ-007 Write-response ports SHALL be: bresp out 2; buser out USER_WIDTH; bvalid out 1; bready in 1.
REQ-008 Read-address ports SHALL be: araddr in ADDR_WIDTH; arlen in 8; arvalid in 1; arready out 1.
REQ-009 Read-data ports SHALL be: rdata out DATA_WIDTH; rresp out 2; rlast out 1; ruser out USER_WIDTH; rvalid out 1; rready in 1.

Function
REQ-010 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-011 On AW handshake, the FSM SHALL latch word index awaddr[ADDR_WIDTH-1:log2(STROBE_WIDTH)], latch awlen, clear the beat counter and go W_IDLE->W_DATA.
REQ-012 Each W handshake SHALL write wdata to the current word, increment the word index modulo depth (wrap to 0) and increment the beat counter.
REQ-013 On the beat where counter==awlen, the FSM SHALL go W_DATA->W_RESP regardless of wlast.
REQ-014 bresp SHALL be SLVERR (2'b10) if wlast was 1 on any beat other than the last or 0 on the last beat; otherwise OKAY (2'b00).
REQ-015 On B handshake, the FSM SHALL go W_RESP->W_IDLE; bvalid/bresp SHALL hold stable until bready.
REQ-016 Read FSM SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE, rvalid=1 only in R_DATA.
REQ-017 On AR handshake, the block SHALL register rdata from the addressed word and assert rvalid on the next cycle (1-cycle latency).
REQ-018 On each R handshake that is not last, rdata SHALL advance to the next wrapped word in the following cycle with no bubble.
REQ-019 rlast SHALL be 1 when the beat counter==arlen; an R handshake with rlast SHALL return the FSM to R_IDLE.
REQ-020 rdata/rlast SHALL hold stable while rvalid=1 and rready=0.
REQ-021 rresp SHALL be OKAY; buser and ruser SHALL be 0.
REQ-022 Read and write FSMs SHALL run independently; a read load and a write to the same word in the same cycle SHALL return old data (read-first).

Reset
REQ-023 While aresetn=0, all outputs SHALL be 0 and both FSMs SHALL be idle; awready/arready SHALL go to 1 on the first aclk rising edge after release.
REQ-024 Reset mid-burst SHALL abandon the burst without a response; memory contents SHALL NOT be reset.

Configuration
REQ-025 With AXI_MEM_WSTRB_EN defined, only bytes whose wstrb bit is 1 SHALL be written; without it, wstrb SHALL be ignored and the full word SHALL be written.

Structure
REQ-026 Package axi_pkg SHALL hold LEN_WIDTH=8, RESP_WIDTH=2, RESP_OKAY, RESP_SLVERR, and the write/read state enums.
REQ-027 Storage SHALL be sub-module axi_mem_ram (word array, byte-enable write port, synchronous read port).

Verification
REQ-028 Write awaddr=0x10, awlen=3 with data 0xA0..0xA3 and wlast on beat 4 -> bresp=OKAY; then read araddr=0x10, arlen=3 -> rdata 0xA0..0xA3 with rlast on beat 4.
REQ-029 Write awaddr=0xFC, awlen=1 (wrap) with 0x11, 0x22 -> word 63=0x11 and word 0=0x22 on read-back.
REQ-030 Write awlen=2 with wlast on beat 2 -> 3 beats accepted and bresp=SLVERR.
REQ-031 Read with rready toggling 1/0 for 4 beats -> rdata/rlast stable while stalled; no beats lost.
REQ-032 With AXI_MEM_WSTRB_EN defined, write 0xFFFFFFFF over 0x12345678 with wstrb=4'b0101 -> read returns 0x12FF56FF; without the macro -> 0xFFFFFFFF.
REQ-033 Assert aresetn=0 mid-read on beat 2 of 4 -> rvalid=0 immediately, arready=1 after release, and previously written data is intact.
